// File: rtl/mips32_fetch_queue.sv
// Instruction-fetch front end: credit-limited word requests to imem, in-order response
// capture into a DEPTH-entry prefetch FIFO, and redirect flush with in-flight discard.
module mips32_fetch_queue #(
    parameter int          ADDR_W   = 10,
    parameter int          DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    output logic                             imem_req_valid,
    input  logic                             imem_req_ready,
    output logic [ADDR_W-1:0]                imem_req_addr,
    input  logic                             imem_rsp_valid,
    input  logic [31:0]                      imem_rsp_data,
    input  logic                             redirect_valid,
    input  logic [ADDR_W-1:0]                redirect_target,
    input  logic                             halt,
    output logic                             if_id_valid,
    input  logic                             if_id_ready,
    output logic [31:0]                      if_id_ir,
    output logic [31:0]                      if_id_npc,
    output logic [$clog2(DEPTH+1)-1:0]       fq_count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  discard;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [31:0]       ir_mem  [DEPTH];
    logic [ADDR_W-1:0] npc_mem [DEPTH];

    logic credit_ok;
    logic req_fire;
    logic enq;
    logic deq;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Buffered plus in-flight words never exceed DEPTH, so a response always finds room.
    assign credit_ok      = ({1'b0, count} + {1'b0, outstanding}) < (CNT_W + 1)'(DEPTH);
    assign imem_req_valid = rst_n & ~halt & ~redirect_valid & credit_ok;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign enq = rst_n & imem_rsp_valid & (discard == '0) & ~redirect_valid;

    assign if_id_valid = rst_n & ~redirect_valid & (count != '0);
    assign deq         = if_id_valid & if_id_ready;
    assign if_id_ir    = ir_mem[rd_ptr];
    assign if_id_npc   = 32'(npc_mem[rd_ptr]);
    assign fq_count    = rst_n ? count : '0;

    // Control state: request/response bookkeeping and FIFO pointers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= ADDR_W'(RESET_PC);
            rsp_pc      <= ADDR_W'(RESET_PC);
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
            if (redirect_valid) begin
                // Every word still in flight after this edge belongs to the old stream;
                // outstanding already includes any earlier pending discards.
                pc      <= redirect_target;
                rsp_pc  <= redirect_target;
                discard <= outstanding - CNT_W'(imem_rsp_valid);
                count   <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
            end else begin
                if (req_fire)
                    pc <= pc + ADDR_W'(1);
                if (imem_rsp_valid && (discard != '0))
                    discard <= discard - CNT_W'(1);
                if (enq) begin
                    wr_ptr <= next_ptr(wr_ptr);
                    rsp_pc <= rsp_pc + ADDR_W'(1);
                end
                if (deq)
                    rd_ptr <= next_ptr(rd_ptr);
                case ({enq, deq})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Queue storage: data only, written on enqueue
    always_ff @(posedge clk) begin
        if (enq) begin
            ir_mem[wr_ptr]  <= imem_rsp_data;
            npc_mem[wr_ptr] <= rsp_pc + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Directed bench for mips32_fetch_queue with an in-order, fixed-latency memory responder.
module tb_mips32_fetch_queue;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              imem_req_valid;
    logic              imem_req_ready = 1'b1;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_target = '0;
    logic              halt = 1'b0;
    logic              if_id_valid;
    logic              if_id_ready = 1'b1;
    logic [31:0]       if_id_ir;
    logic [31:0]       if_id_npc;
    logic [2:0]        fq_count;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 1;
    int cyc     = 0;
    int q_addr[$];
    int q_due[$];

    mips32_fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .halt(halt),
        .if_id_valid(if_id_valid),
        .if_id_ready(if_id_ready),
        .if_id_ir(if_id_ir),
        .if_id_npc(if_id_npc),
        .fq_count(fq_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input int a);
        return 32'hC0DE_0000 + 32'(a);
    endfunction

    // Memory: a request fired in cycle t answers in cycle t+lat, in order
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            q_addr.delete();
            q_due.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                q_addr.push_back(int'(imem_req_addr));
                q_due.push_back(cyc - 1 + lat);
            end
            if (q_addr.size() > 0 && q_due[0] <= cyc) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mdata(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    // Leaves the bench at cycle 0 of a fresh stream: reset applied, rst_n just released
    task automatic do_reset(input int l);
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        if_id_ready    = 1'b1;
        imem_req_ready = 1'b1;
        lat            = l;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (imem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_req_valid k=%0d got %b want 0", k, imem_req_valid);
            end
            n_tests++;
            if (if_id_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_if_id_valid k=%0d got %b want 0", k, if_id_valid);
            end
            n_tests++;
            if (fq_count !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_fq_count k=%0d got %0d want 0", k, fq_count);
            end
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_first_req got valid=%b addr=%0d want valid=1 addr=0",
                     imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_stream();
        do_reset(1);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_tests++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 10'(k)) begin
                n_fail++;
                $display("FAIL stream_req k=%0d got valid=%b addr=%0d want valid=1 addr=%0d",
                         k, imem_req_valid, imem_req_addr, k);
            end
            if (k < 2) begin
                n_tests++;
                if (if_id_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream_early_valid k=%0d got %b want 0", k, if_id_valid);
                end
            end else begin
                n_tests++;
                if (if_id_valid !== 1'b1 || if_id_npc !== 32'(k - 1) || if_id_ir !== mdata(k - 2)) begin
                    n_fail++;
                    $display("FAIL stream_head k=%0d got v=%b npc=%0d ir=%h want v=1 npc=%0d ir=%h",
                             k, if_id_valid, if_id_npc, if_id_ir, k - 1, mdata(k - 2));
                end
            end
        end
    endtask

    task automatic test_stall();
        int fires = 0;
        int max_cnt = 0;
        do_reset(3);
        if_id_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (imem_req_valid && imem_req_ready) fires++;
            if (int'(fq_count) > max_cnt) max_cnt = int'(fq_count);
        end
        n_tests++;
        if (fires != 4) begin
            n_fail++;
            $display("FAIL stall_fires got %0d want 4", fires);
        end
        n_tests++;
        if (max_cnt != 4 || fq_count !== 3'd4) begin
            n_fail++;
            $display("FAIL stall_count got max=%0d now=%0d want 4/4", max_cnt, fq_count);
        end
        n_tests++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_req_blocked got %b want 0", imem_req_valid);
        end
        @(negedge clk);
        if_id_ready = 1'b1;
        #1;
        n_tests++;
        if (if_id_valid !== 1'b1 || if_id_npc !== 32'd1 || if_id_ir !== mdata(0) || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release got v=%b npc=%0d ir=%h req=%b want v=1 npc=1 ir=%h req=0",
                     if_id_valid, if_id_npc, if_id_ir, imem_req_valid, mdata(0));
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 10'd4 || if_id_npc !== 32'd2) begin
            n_fail++;
            $display("FAIL stall_resume got req=%b addr=%0d npc=%0d want req=1 addr=4 npc=2",
                     imem_req_valid, imem_req_addr, if_id_npc);
        end
    endtask

    task automatic test_redirect();
        do_reset(3);
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            redirect_valid  = (k == 3);
            redirect_target = 10'h100;
            #1;
            if (k == 3) begin
                n_tests++;
                if (imem_req_valid !== 1'b0 || if_id_valid !== 1'b0 || imem_rsp_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL redir_cycle got req=%b v=%b rsp=%b want 0 0 1",
                             imem_req_valid, if_id_valid, imem_rsp_valid);
                end
            end
            if (k == 4 || k == 5) begin
                n_tests++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== 10'(32'h100 + k - 4)) begin
                    n_fail++;
                    $display("FAIL redir_req k=%0d got v=%b addr=%h want v=1 addr=%h",
                             k, imem_req_valid, imem_req_addr, 32'h100 + k - 4);
                end
            end
            if (k >= 4 && k <= 7) begin
                n_tests++;
                if (if_id_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL redir_dropped k=%0d got v=%b npc=%h want v=0", k, if_id_valid, if_id_npc);
                end
            end
            if (k == 8) begin
                n_tests++;
                if (if_id_valid !== 1'b1 || if_id_npc !== 32'h101 || if_id_ir !== mdata(32'h100)) begin
                    n_fail++;
                    $display("FAIL redir_first got v=%b npc=%h ir=%h want v=1 npc=101 ir=%h",
                             if_id_valid, if_id_npc, if_id_ir, mdata(32'h100));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset(3);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            redirect_valid  = (k == 3) || (k == 4);
            redirect_target = (k == 3) ? 10'h100 : 10'h200;
            #1;
            if (k == 4) begin
                n_tests++;
                if (imem_req_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_no_fire got %b want 0", imem_req_valid);
                end
            end
            if (k == 5 || k == 6) begin
                n_tests++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== 10'(32'h200 + k - 5)) begin
                    n_fail++;
                    $display("FAIL b2b_req k=%0d got v=%b addr=%h want v=1 addr=%h",
                             k, imem_req_valid, imem_req_addr, 32'h200 + k - 5);
                end
            end
            if (k >= 5 && k <= 8) begin
                n_tests++;
                if (if_id_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_dropped k=%0d got v=%b npc=%h want v=0", k, if_id_valid, if_id_npc);
                end
            end
            if (k == 9) begin
                n_tests++;
                if (if_id_valid !== 1'b1 || if_id_npc !== 32'h201 || if_id_ir !== mdata(32'h200)) begin
                    n_fail++;
                    $display("FAIL b2b_first got v=%b npc=%h ir=%h want v=1 npc=201 ir=%h",
                             if_id_valid, if_id_npc, if_id_ir, mdata(32'h200));
                end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset(1);
        redirect_valid  = 1'b1;
        redirect_target = 10'd1023;
        #1;
        n_tests++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_redirect_req got %b want 0", imem_req_valid);
        end
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            #1;
            n_tests++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== ((k == 1) ? 10'd1023 : 10'(k - 2))) begin
                n_fail++;
                $display("FAIL wrap_req k=%0d got v=%b addr=%0d", k, imem_req_valid, imem_req_addr);
            end
        end
        n_tests++;
        if (if_id_valid !== 1'b1 || if_id_npc !== 32'd0 || if_id_ir !== mdata(1023)) begin
            n_fail++;
            $display("FAIL wrap_npc got v=%b npc=%0d ir=%h want v=1 npc=0 ir=%h",
                     if_id_valid, if_id_npc, if_id_ir, mdata(1023));
        end
    endtask

    task automatic test_halt();
        int fires = 0;
        do_reset(3);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            halt = (k >= 2) && (k <= 6);
            #1;
            if (halt && imem_req_valid && imem_req_ready) fires++;
            if (k == 4 || k == 5) begin
                n_tests++;
                if (if_id_valid !== 1'b1 || if_id_npc !== 32'(k - 3) || fq_count !== 3'd1) begin
                    n_fail++;
                    $display("FAIL halt_drain k=%0d got v=%b npc=%0d cnt=%0d want v=1 npc=%0d cnt=1",
                             k, if_id_valid, if_id_npc, fq_count, k - 3);
                end
            end
            if (k == 6) begin
                n_tests++;
                if (if_id_valid !== 1'b0 || fq_count !== 3'd0) begin
                    n_fail++;
                    $display("FAIL halt_empty got v=%b cnt=%0d want v=0 cnt=0", if_id_valid, fq_count);
                end
            end
            if (k == 7) begin
                n_tests++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== 10'd2) begin
                    n_fail++;
                    $display("FAIL halt_resume got v=%b addr=%0d want v=1 addr=2", imem_req_valid, imem_req_addr);
                end
            end
        end
        n_tests++;
        if (fires != 0) begin
            n_fail++;
            $display("FAIL halt_no_fire got %0d fires want 0", fires);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        if_id_ready = 1'b0;
        for (int k = 1; k < 7; k++) @(negedge clk);
        #1;
        n_tests++;
        if (fq_count !== 3'd4 || if_id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_full got cnt=%0d v=%b want cnt=4 v=1", fq_count, if_id_valid);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (imem_req_valid !== 1'b0 || if_id_valid !== 1'b0 || fq_count !== 3'd0) begin
            n_fail++;
            $display("FAIL rstmid_during got req=%b v=%b cnt=%0d want 0 0 0",
                     imem_req_valid, if_id_valid, fq_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (if_id_valid !== 1'b0 || fq_count !== 3'd0) begin
            n_fail++;
            $display("FAIL rstmid_after got v=%b cnt=%0d want v=0 cnt=0", if_id_valid, fq_count);
        end
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL rstmid_first_req got v=%b addr=%0d want v=1 addr=0", imem_req_valid, imem_req_addr);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_halt();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
